// File: rtl/sixteen_lac_accum.sv
// sixteen_lac: 16-bit carry-lookahead adder built from four 4-bit groups.
//   Inside each group the carry ripples across four bits. Group generate and
//   propagate terms feed a lookahead unit that forms every group carry-in
//   directly from ci.
//   a, b : operands      ci : carry-in
//   s    : sum           c1 : carry-out of bit 15
//
// sixteen_lac_accum: sequential accumulator downstream of sixteen_lac.
//   Collects COUNT operands over an input handshake. Each operand is added to
//   or subtracted from a running 16-bit sum. The final sum, the carry-out of
//   the last beat and a sticky signed-overflow flag are then presented on an
//   output handshake that holds until the consumer takes it.
//   clk, rst (async, active high), clr (sync abort)
//   in_valid/in_ready/din/op  : operand stream (op=1 subtracts)
//   out_valid/out_ready       : result handshake
//   sum/co/ovf                : result; all zero whenever out_valid=0
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both high. The producer holds its data stable until it sees ready.
// out_valid and the result stay asserted and unchanged until out_ready is seen.

module sixteen_lac (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        c1
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [4:0]  grp_c;
  logic [15:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
    end
  end

  // Lookahead across groups: each group carry-in depends only on ci and the
  // group terms. No carry passes from one group to the next.
  always_comb begin
    grp_c[0] = ci;
    grp_c[1] = grp_g[0] | (grp_p[0] & ci);
    grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & ci);
    grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & ci);
    grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & ci);
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = grp_c[k];
      c[4*k+1] = g[4*k]   | (p[4*k]   & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & c[4*k+1]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & c[4*k+2]);
    end
  end

  assign s  = p ^ c;
  assign c1 = grp_c[4];

endmodule

module sixteen_lac_accum #(
  parameter int COUNT = 4,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] din,
  input  logic        op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sum,
  output logic        co,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [15:0]      acc;
  logic [CNT_W-1:0] cnt;
  logic             co_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [15:0]      add_a;
  logic [15:0]      add_b;
  logic [15:0]      add_s;
  logic             add_c1;
  logic             beat;
  logic             beat_ovf;
  logic             last_beat;

  // In IDLE the accumulator counts as zero, so a block never inherits a
  // previous sum.
  assign add_a = (state == IDLE) ? 16'h0000 : acc;
  // Subtraction is a + ~b + 1, so the adder's carry-in carries the +1.
  assign add_b = op ? ~din : din;

  sixteen_lac u_adder (
    .a  (add_a),
    .b  (add_b),
    .ci (op),
    .s  (add_s),
    .c1 (add_c1)
  );

  // in_ready_q is already low in DONE. The state term keeps a beat out of a
  // handoff cycle even if the ready flag were wrong.
  assign beat      = in_valid && in_ready_q && (state != DONE);
  assign beat_ovf  = (add_a[15] == add_b[15]) && (add_s[15] != add_a[15]);
  assign last_beat = (COUNT == 1) || (cnt == CNT_W'(COUNT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= 16'h0000;
      cnt         <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clr) begin
      state       <= IDLE;
      acc         <= 16'h0000;
      cnt         <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // After reset release the ready flag comes up here, one edge later.
          in_ready_q <= 1'b1;
          if (beat) begin
            acc   <= add_s;
            co_q  <= add_c1;
            ovf_q <= beat_ovf;
            cnt   <= CNT_W'(1);
            if (COUNT == 1) begin
              state       <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (beat) begin
            acc   <= add_s;
            co_q  <= add_c1;
            ovf_q <= ovf_q | beat_ovf;
            cnt   <= cnt + CNT_W'(1);
            if (last_beat) begin
              state       <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            acc         <= 16'h0000;
            cnt         <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          acc         <= 16'h0000;
          cnt         <= '0;
          co_q        <= 1'b0;
          ovf_q       <= 1'b0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  // The result is masked so that it reads as zero whenever no output is offered.
  assign sum       = out_valid_q ? acc   : 16'h0000;
  assign co        = out_valid_q ? co_q  : 1'b0;
  assign ovf       = out_valid_q ? ovf_q : 1'b0;

endmodule
